mult_cmd_driver: RTL



---
 rtl/mult_cmd_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/mult_cmd_driver.sv
// mult_cmd_driver: sequences LOAD_A/LOAD_B/START/wait/READ_LO/READ_HI on the multiplier
// wrapper bus and returns the 16-bit product over a valid/ready response port.
module mult_cmd_driver #(
    parameter int CALC_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_product,
    output logic        busy,
    output logic [2:0]  comm,
    output logic [7:0]  in_8b,
    input  logic [7:0]  out_8b
);
    typedef enum logic [3:0] {IDLE, LD_A, LD_B, GO, WAIT, RD_LO, RD_HI, CAP, RESP} state_t;
    localparam logic [2:0] NOP = 3'd0, LOAD_A = 3'd1, LOAD_B = 3'd2, START = 3'd3,
                           READ_LO = 3'd4, READ_HI = 3'd5;

    state_t             state_q;
    logic [7:0]         b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         comm_q;
    logic [7:0]         in_q;
    logic               rsp_valid_q;
    logic [15:0]        product_q;

    // comm/in_8b are loaded on the edge that enters a state, so they are valid throughout it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            b_q         <= 8'h00;
            cnt_q       <= '0;
            comm_q      <= NOP;
            in_q        <= 8'h00;
            rsp_valid_q <= 1'b0;
            product_q   <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    b_q     <= req_b;
                    in_q    <= req_a;
                    comm_q  <= LOAD_A;
                    state_q <= LD_A;
                end
                LD_A: begin
                    in_q    <= b_q;
                    comm_q  <= LOAD_B;
                    state_q <= LD_B;
                end
                LD_B: begin
                    in_q    <= 8'h00;
                    comm_q  <= START;
                    state_q <= GO;
                end
                GO: begin
                    cnt_q   <= CNT_W'(CALC_CYCLES);
                    comm_q  <= (CALC_CYCLES == 0) ? READ_LO : NOP;
                    state_q <= (CALC_CYCLES == 0) ? RD_LO : WAIT;
                end
                WAIT: if (cnt_q == CNT_W'(1)) begin
                    comm_q  <= READ_LO;
                    state_q <= RD_LO;
                end else begin
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                RD_LO: begin
                    comm_q  <= READ_HI;
                    state_q <= RD_HI;
                end
                RD_HI: begin
                    product_q[7:0] <= out_8b;
                    comm_q         <= NOP;
                    state_q        <= CAP;
                end
                CAP: begin
                    product_q[15:8] <= out_8b;
                    rsp_valid_q     <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    comm_q  <= NOP;
                    in_q    <= 8'h00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign comm        = comm_q;
    assign in_8b       = in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = product_q;
endmodule
